// File: rtl/circular_left_shift_seq.sv
// Sequential rotate-left of one operand by k with valid/ready handshake; 1-operand deep.
// Latency k+1 cycles (iterative) or 1 cycle with CIRC_LEFT_SHIFT_FAST_EN defined; result holds in DONE until out_ready.
module circular_left_shift_seq #(
  parameter int WIDTH = 4,
  parameter int KW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [KW-1:0]    k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] data;
  logic [KW-1:0]    cnt;

`ifdef CIRC_LEFT_SHIFT_FAST_EN
  // Repeated single-step rotation lets k >= WIDTH wrap exactly as the iterative build does.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input logic [KW-1:0] amt);
    logic [WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < (1 << KW); i++) begin
      if (i < int'(amt)) r = {r[WIDTH-2:0], r[WIDTH-1]};
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef CIRC_LEFT_SHIFT_FAST_EN
            data  <= rotl(in, k);
            cnt   <= '0;
            state <= DONE;
`else
            data  <= in;
            cnt   <= k;
            state <= (k == '0) ? DONE : SHIFT;
`endif
          end
        end
        SHIFT: begin
          data <= {data[WIDTH-2:0], data[WIDTH-1]};
          cnt  <= cnt - 1'b1;
          if (cnt == KW'(1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out       = data;

endmodule
